// File: rtl/mul_pkg.sv
// Shared definitions for the multiply sequencer: state encoding and defaults.
package mul_pkg;

  localparam int MUL_WIDTH        = 32;
  localparam int MUL_DONE_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_OUT       = 3'd4
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Connection between the sequencer and the external unsigned bit-pair
// multiplier core. The sequencer is the master; the core is the slave.
interface mul_sequencer_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
);

  logic               mul_start;
  logic [WIDTH-1:0]   mul_multiplier;
  logic [WIDTH-1:0]   mul_multiplicand;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_result;

  modport master (
    output mul_start,
    output mul_multiplier,
    output mul_multiplicand,
    input  mul_done,
    input  mul_result
  );

  modport slave (
    input  mul_start,
    input  mul_multiplier,
    input  mul_multiplicand,
    output mul_done,
    output mul_result
  );

endinterface

// File: rtl/mul_signfix.sv
// Conditional two's-complement negate (used as abs for operands and as
// sign restore for the product) plus a "fits in half the width" check.
module mul_signfix #(
  parameter int W     = 32,
  parameter int LANES = 1
) (
  input  logic [LANES-1:0][W-1:0] value,
  input  logic [LANES-1:0]        negate,
  input  logic                    signed_mode,
  output logic [LANES-1:0][W-1:0] result,
  output logic [LANES-1:0]        fits
);

  localparam int HALF = W / 2;

  // Negating the most-negative value yields its unsigned magnitude (no
  // saturation), and negating zero yields zero, so no special cases.
  always_comb begin
    result = '0;
    fits   = '0;
    for (int i = 0; i < LANES; i++) begin
      result[i] = negate[i] ? (~value[i] + W'(1)) : value[i];
      if (signed_mode)
        fits[i] = (&result[i][W-1:HALF-1]) | ~(|result[i][W-1:HALF-1]);
      else
        fits[i] = ~(|result[i][W-1:HALF]);
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Sequencer wrapping an external unsigned multiplier core: takes signed or
// unsigned operands, launches the core on magnitudes, restores the sign and
// reports whether the product fits in WIDTH bits. A core that never
// completes is caught by a timeout and reported as an error.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on state and mul_done, never on in_valid;
// out_valid depends only on state, and once high the result is held stable
// until the out_ready transfer.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH        = MUL_WIDTH,
  parameter int DONE_TIMEOUT = MUL_DONE_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  mul_sequencer_if.master    core,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_fits,
  output logic               out_error,
  output mul_state_t         dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(DONE_TIMEOUT + 1) + 1;

  mul_state_t state_q, state_d;

  logic [WIDTH-1:0] multiplier_q, multiplicand_q;
  logic             cap_signed_q;
  logic             result_neg_q;
  logic [CW-1:0]    to_cnt_q;
  logic [CW-1:0]    cnt_inc;
  logic             timeout_hit;

  logic [1:0][WIDTH-1:0] op_value;
  logic [1:0]            op_negate;
  logic [1:0][WIDTH-1:0] op_mag;
  logic [1:0]            operand_fits_unused;

  logic [0:0][PW-1:0] prod_fixed;
  logic [0:0]         prod_fits;

  assign op_value  = {in_b, in_a};
  assign op_negate = {in_signed & in_b[WIDTH-1], in_signed & in_a[WIDTH-1]};

  mul_signfix #(.W(WIDTH), .LANES(2)) u_operand_fix (
    .value       (op_value),
    .negate      (op_negate),
    .signed_mode (in_signed),
    .result      (op_mag),
    .fits        (operand_fits_unused)
  );

  mul_signfix #(.W(PW), .LANES(1)) u_product_fix (
    .value       (core.mul_result),
    .negate      (result_neg_q),
    .signed_mode (cap_signed_q),
    .result      (prod_fixed),
    .fits        (prod_fits)
  );

  // to_cnt_q holds cycles elapsed since launch; the launch cycle loads 1.
  assign cnt_inc     = to_cnt_q + CW'(1);
  assign timeout_hit = (cnt_inc >= CW'(DONE_TIMEOUT));

  assign in_ready              = (state_q == S_IDLE) && core.mul_done;
  assign out_valid             = (state_q == S_OUT);
  assign core.mul_start        = (state_q == S_LAUNCH);
  assign core.mul_multiplier   = multiplier_q;
  assign core.mul_multiplicand = multiplicand_q;
  assign dbg_state             = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; WAIT_BUSY ignores a done level left over from before
  // the launch and only moves on once the core has dropped it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (in_valid && core.mul_done) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (timeout_hit)         state_d = S_OUT;
        else if (!core.mul_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (core.mul_done || timeout_hit) state_d = S_OUT;
      S_OUT:       if (out_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Operand capture, timeout counting and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multiplier_q   <= '0;
      multiplicand_q <= '0;
      cap_signed_q   <= 1'b0;
      result_neg_q   <= 1'b0;
      to_cnt_q       <= '0;
      out_product    <= '0;
      out_fits       <= 1'b0;
      out_error      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            multiplier_q   <= op_mag[0];
            multiplicand_q <= op_mag[1];
            cap_signed_q   <= in_signed;
            result_neg_q   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          end
        end
        S_LAUNCH: to_cnt_q <= CW'(1);
        S_WAIT_BUSY, S_WAIT_DONE: begin
          to_cnt_q <= cnt_inc;
          if ((state_q == S_WAIT_DONE) && core.mul_done) begin
            out_product <= prod_fixed[0];
            out_fits    <= prod_fits[0];
            out_error   <= 1'b0;
          end else if (timeout_hit) begin
            out_product <= '0;
            out_fits    <= 1'b0;
            out_error   <= 1'b1;
          end
        end
        S_OUT: if (out_ready) to_cnt_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural multiplier core.
module tb_mul_sequencer;
  import mul_pkg::*;

  localparam int W        = MUL_WIDTH;
  localparam int T        = MUL_DONE_TIMEOUT;
  localparam int CORE_LAT = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, in_signed;
  logic [W-1:0]     in_a, in_b;
  logic             out_valid, out_ready, out_fits, out_error;
  logic [2*W-1:0]   out_product;
  mul_state_t       dbg_state;
  logic             core_hang;
  int               core_cnt;

  mul_sequencer_if #(.WIDTH(W)) core_if ();

  mul_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .core        (core_if.master),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_fits    (out_fits),
    .out_error   (out_error),
    .dbg_state   (dbg_state)
  );

  // Core model: drops done on the start edge, raises it CORE_LAT edges later.
  // In hang mode it ignores start and leaves done high forever.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_if.mul_done   <= 1'b1;
      core_if.mul_result <= '0;
      core_cnt           <= 0;
    end else if (core_if.mul_start && core_if.mul_done && !core_hang) begin
      core_if.mul_done   <= 1'b0;
      core_if.mul_result <= {{W{1'b0}}, core_if.mul_multiplier} *
                            {{W{1'b0}}, core_if.mul_multiplicand};
      core_cnt           <= CORE_LAT;
    end else if (!core_if.mul_done) begin
      if (core_cnt == 1) core_if.mul_done <= 1'b1;
      else               core_cnt <= core_cnt - 1;
    end
  end

  // Monitors (single writer each).
  int start_count = 0;
  int overlap_count = 0;
  int valid_seen = 0;
  int bad_accept = 0;
  always @(negedge clk) begin
    if (core_if.mul_start)            start_count++;
    if (in_ready && out_valid)        overlap_count++;
    if (out_valid)                    valid_seen++;
    if (in_ready && dbg_state != S_IDLE) bad_accept++;
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
    check("accept_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 1;
    while (!out_valid && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check("out_valid_seen", {63'b0, out_valid}, 64'd1);
  endtask

  task automatic finish_op(input string tag, input logic [2*W-1:0] exp_p,
                           input logic exp_fits, input logic exp_err);
    check({tag, "_prod"}, out_product, exp_p);
    check({tag, "_fits"}, {63'b0, out_fits}, {63'b0, exp_fits});
    check({tag, "_err"},  {63'b0, out_error}, {63'b0, exp_err});
    check({tag, "_nordy"}, {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done"}, {63'b0, out_valid}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] exp_p, input logic exp_fits);
    int lat;
    send(a, b, s);
    wait_valid(200, lat);
    finish_op(tag, exp_p, exp_fits, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int s0;
    int v0;
    in_valid = 0; in_a = '0; in_b = '0; in_signed = 0;
    out_ready = 0; core_hang = 0; rst_n = 0;
    repeat (3) @(negedge clk);

    check("rst_in_ready",  {63'b0, in_ready}, 64'd1);
    check("rst_start",     {63'b0, core_if.mul_start}, 64'd0);
    check("rst_mplier",    {32'b0, core_if.mul_multiplier}, 64'd0);
    check("rst_mcand",     {32'b0, core_if.mul_multiplicand}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_product",   out_product, 64'd0);
    check("rst_fits",      {63'b0, out_fits}, 64'd0);
    check("rst_error",     {63'b0, out_error}, 64'd0);
    check("rst_state",     {61'b0, dbg_state}, {61'b0, S_IDLE});

    rst_n = 1;
    @(negedge clk);

    // -3 x 5 signed, with latency and operand magnitude checks
    send(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_valid(200, lat);
    check("lat_m3x5", lat, CORE_LAT + 3);
    check("mag_a_m3", {32'b0, core_if.mul_multiplier}, 64'd3);
    check("mag_b_5",  {32'b0, core_if.mul_multiplicand}, 64'd5);
    finish_op("m3x5", 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0);

    // most-negative squared, signed
    send(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_valid(200, lat);
    check("mag_minneg", {32'b0, core_if.mul_multiplier}, 64'h8000_0000);
    finish_op("minneg_sq", 64'h4000_0000_0000_0000, 1'b0, 1'b0);

    run_op("umax_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);

    // 31415 x 113 unsigned, backpressure for 10 cycles
    s0 = start_count;
    send(32'd31415, 32'd113, 1'b0);
    wait_valid(200, lat);
    for (int i = 0; i < 10; i++) begin
      check("hold_prod",  out_product, 64'd3549895);
      check("hold_valid", {63'b0, out_valid}, 64'd1);
      @(negedge clk);
    end
    check("one_start", start_count - s0, 64'd1);
    finish_op("u31415", 64'd3549895, 1'b1, 1'b0);

    run_op("zero_neg",  32'd0, 32'hFFFF_FFF9, 1'b1, 64'd0, 1'b1);
    run_op("sfit_lo",   32'hFFFF_0000, 32'h0000_8000, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    run_op("sfit_hi",   32'h0001_0000, 32'h0000_8000, 1'b1, 64'h0000_0000_8000_0000, 1'b0);
    run_op("ufit_hi",   32'h0001_0000, 32'h0000_8000, 1'b0, 64'h0000_0000_8000_0000, 1'b1);
    run_op("m1xm1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, 1'b1);

    // core never drops done: timeout T cycles after the launch cycle
    core_hang = 1;
    send(32'd9, 32'd9, 1'b0);
    wait_valid(300, lat);
    check("timeout_lat", lat, T + 1);
    finish_op("timeout", 64'd0, 1'b0, 1'b1);
    core_hang = 0;

    // reset while waiting for the core
    send(32'd5, 32'd5, 1'b1);
    for (int k = 0; k < 50 && dbg_state != S_WAIT_DONE; k++) @(negedge clk);
    check("reach_wait_done", {61'b0, dbg_state}, {61'b0, S_WAIT_DONE});
    rst_n = 0;
    #1;
    check("mrst_state",  {61'b0, dbg_state}, {61'b0, S_IDLE});
    check("mrst_ready",  {63'b0, in_ready}, 64'd1);
    check("mrst_start",  {63'b0, core_if.mul_start}, 64'd0);
    check("mrst_mplier", {32'b0, core_if.mul_multiplier}, 64'd0);
    check("mrst_valid",  {63'b0, out_valid}, 64'd0);
    check("mrst_prod",   out_product, 64'd0);
    check("mrst_error",  {63'b0, out_error}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    v0 = valid_seen;
    repeat (30) @(negedge clk);
    check("abandoned", valid_seen - v0, 64'd0);
    run_op("7xm6", 32'd7, 32'hFFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 1'b1);

    // back-to-back with in_valid held high and out_ready high
    out_ready = 1;
    in_valid = 1;
    in_a = 32'd1000; in_b = 32'd1000; in_signed = 0;
    exp_q.push_back(64'd1000000);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
      check("b2b_accept", {63'b0, in_ready}, 64'd1);
      @(negedge clk);
      if (i == 0) begin
        in_a = 32'hFFFF_FFFE; in_b = 32'hFFFF_FFFD; in_signed = 1;
        exp_q.push_back(64'd6);
      end else if (i == 1) begin
        in_a = 32'd12345; in_b = 32'hFFFF_FFFF; in_signed = 1;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_CFC7);
      end else begin
        in_valid = 0;
      end
      wait_valid(200, lat);
      check("b2b_prod", out_product, exp_q.pop_front());
    end
    @(negedge clk);
    out_ready = 0;
    check("no_overlap", overlap_count, 64'd0);
    check("idle_only_accept", bad_accept, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; product is 2*WIDTH.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 64: maximum cycles to wait for core completion.
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  sequencer can accept a request.
REQ-007 in_a, in_b  input  WIDTH each  operands.
REQ-008 in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 mul_start  output  1  launch pulse to the unsigned bit-pair multiplier core.
REQ-010 mul_multiplier, mul_multiplicand  output  WIDTH each  operand magnitudes to the core.
REQ-011 mul_done  input  1  core idle/complete flag; high out of core reset.
REQ-012 mul_result  input  2*WIDTH  unsigned core product.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_product  output  2*WIDTH  final product, signed or unsigned per captured in_signed.
REQ-016 out_fits  output  1  product representable in WIDTH bits (signed range if signed, else unsigned).
REQ-017 out_error  output  1  core timeout; out_product is 0 when set.

Function
REQ-018 States IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, OUT; in_ready = 1 only in IDLE.
REQ-019 IDLE: in_valid=1 captures in_a, in_b, in_signed, result sign (a_neg XOR b_neg, signed mode only) and magnitudes; -> LAUNCH.
REQ-020 Magnitude of most-negative value (0x80000000 at WIDTH=32) SHALL be 2^(WIDTH-1) unsigned, no saturation.
REQ-021 LAUNCH: mul_start=1 for exactly one cycle, operands registered and stable from LAUNCH until OUT; -> WAIT_BUSY.
REQ-022 mul_start SHALL never be high outside LAUNCH (prevents core re-launch on completion).
REQ-023 LAUNCH is entered only when mul_done=1; otherwise IDLE holds in_ready=0 until mul_done=1.
REQ-024 WAIT_BUSY: mul_done=0 -> WAIT_DONE; stale high done from before launch SHALL NOT complete the operation.
REQ-025 WAIT_DONE: mul_done=1 -> capture mul_result, negate (2*WIDTH two's complement) if result sign set, -> OUT.
REQ-026 Timeout counter counts cycles in WAIT_BUSY+WAIT_DONE; reaching DONE_TIMEOUT -> OUT with out_error=1, out_product=0, out_fits=0.
REQ-027 OUT: out_valid=1, outputs held stable until out_ready=1; handshake cycle -> IDLE.
REQ-028 out_valid and in_ready SHALL never both be 1; no new request accepted in the handshake cycle (one-cycle bubble).
REQ-029 out_fits signed: upper WIDTH+1 bits of out_product all equal; unsigned: upper WIDTH bits zero.
REQ-030 Zero operand SHALL give out_product=0, sign ignored (never -0 artefacts; two's complement 0 stays 0).
REQ-031 Latency with core nominal 18 cycles start-to-done: in_valid accept to out_valid = core latency + 3 cycles.

Reset
REQ-032 reset=0 asynchronously: state IDLE, in_ready=1, mul_start=0, mul operands 0, out_valid=0, out_product=0, out_fits=0, out_error=0, timeout counter 0.
REQ-033 Reset mid-operation SHALL abandon the operation; no output produced afterwards for it.

Structure
REQ-034 State encoding, WIDTH default and DONE_TIMEOUT default SHALL live in shared package mul_pkg.
REQ-035 One sub-module mul_signfix SHALL hold abs/negate and fits-check logic, instantiated once for operands and once for product.
REQ-036 Core SHALL be external; sequencer connects only through mul_* ports.

Verification
REQ-037 Signed -3 x 5 -> out_product 0xFFFFFFFFFFFFFFF1, out_fits=1, out_error=0.
REQ-038 Signed 0x80000000 x 0x80000000 -> 0x4000000000000000, out_fits=0; unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001, out_fits=0.
REQ-039 Unsigned 31415 x 113 with out_ready held 0 for 10 cycles -> out_product 3549895 held stable, mul_start pulsed exactly once.
REQ-040 Core model never drops mul_done -> out_error=1 exactly DONE_TIMEOUT cycles after LAUNCH, out_product=0.
REQ-041 reset asserted in WAIT_DONE -> all outputs at reset values immediately; next request 7 x -6 -> 0xFFFFFFFFFFFFFFD6.
REQ-042 Back-to-back requests with in_valid held high -> each accepted only in IDLE, products correct in order.
